melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 16 +
 rtl/beat_timer.sv | 32 +++
 rtl/melody_sequencer.sv | 108 ++++++++++
 tb/tb_melody_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: controller states,
// default note width and the rest (silence) code sent to the tone generators.
package melody_pkg;

  localparam int NOTE_W_DEFAULT = 6;

  localparam logic [NOTE_W_DEFAULT-1:0] REST_NOTE = '1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/beat_timer.sv
// Step-length timer: counts enabled cycles and wraps after BEAT_CYCLES of them,
// flagging the wrapping cycle on tick.
module beat_timer #(
  parameter int BEAT_CYCLES = 12_500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic last,
  output logic tick
);

  localparam int CNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: registered state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

  assign last = (count == TERMINAL);
  assign tick = enable && last;

endmodule

// File: rtl/melody_sequencer.sv
// Steps a note index through a song at a fixed beat rate with pause/stop control.
// Optional macro SEQ_LOOP_EN adds a loop input that wraps the song instead of ending it.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_LEN    = 47,
  parameter int NOTE_W      = NOTE_W_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
`ifdef SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              beat_tick,
  output logic              busy,
  output logic              done
);

  localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(SONG_LEN - 1);

  seq_state_e state;
  logic       active;
  logic       timer_en;
  logic       timer_clr;
  logic       last;
  logic       tick;
  logic       wrap;

`ifdef SEQ_LOOP_EN
  assign wrap = loop;
`else
  assign wrap = 1'b0;
`endif

  assign active = (state == PLAY) || (state == PAUSE);

  // A pause arriving on the final count of a step still lets that boundary complete.
  assign timer_en  = active && !stop && (!pause || ((state == PLAY) && last));
  assign timer_clr = !active || stop;

  beat_timer #(
    .BEAT_CYCLES(BEAT_CYCLES)
  ) u_beat_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .enable  (timer_en),
    .clear   (timer_clr),
    .last    (last),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      note       <= '1;
      note_valid <= 1'b0;
      beat_tick  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state      <= PLAY;
            note       <= '0;
            note_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        PLAY, PAUSE: begin
          if (stop) begin
            state      <= IDLE;
            note       <= '1;
            note_valid <= 1'b0;
            busy       <= 1'b0;
          end else begin
            state <= pause ? PAUSE : PLAY;
            if (tick) begin
              beat_tick <= 1'b1;
              if (note != LAST_NOTE) begin
                note <= note + NOTE_W'(1);
              end else if (wrap) begin
                note <= '0;
              end else begin
                state      <= DONE;
                note       <= '1;
                note_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer (BEAT_CYCLES=4, SONG_LEN=3): directed
// scenarios with literal expectations, then randomized control against a step model.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int BC  = 4;
  localparam int LEN = 3;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       pause    = 1'b0;
  logic       loop     = 1'b0;
  logic [5:0] note;
  logic       note_valid;
  logic       beat_tick;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  // Model: where the song is, in plain step/elapsed-cycle terms.
  int m_state   = M_IDLE;
  bit m_paused  = 1'b0;
  int m_note    = 0;
  int m_elapsed = 0;
  bit m_tick    = 1'b0;
  bit m_done    = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  melody_sequencer #(
    .BEAT_CYCLES(BC),
    .SONG_LEN   (LEN),
    .NOTE_W     (6)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
`ifdef SEQ_LOOP_EN
    .loop      (loop),
`endif
    .note      (note),
    .note_valid(note_valid),
    .beat_tick (beat_tick),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit st, input bit p, input bit l);
    m_tick = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_state   = M_IDLE;
      m_paused  = 1'b0;
      m_elapsed = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (s && !st) begin
            m_state   = M_BUSY;
            m_note    = 0;
            m_elapsed = 0;
            m_paused  = 1'b0;
          end
        end
        M_DONE: m_state = M_IDLE;
        default: begin
          if (st) begin
            m_state = M_IDLE;
          end else begin
            if (!p || (!m_paused && m_elapsed == BC - 1)) begin
              m_elapsed++;
              if (m_elapsed == BC) begin
                m_elapsed = 0;
                m_tick    = 1'b1;
                if (m_note < LEN - 1) begin
                  m_note++;
                end else if (l && LOOP_EN) begin
                  m_note = 0;
                end else begin
                  m_state = M_DONE;
                  m_done  = 1'b1;
                end
              end
            end
            m_paused = p;
          end
        end
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input bit r, input bit s, input bit st, input bit p, input bit l);
    reset = r;
    start = s;
    stop  = st;
    pause = p;
    loop  = l;
    @(posedge CLOCK_50);
    model_step(r, s, st, p, l);
    @(negedge CLOCK_50);
    check("note",       note,       (m_state == M_BUSY) ? 32'(m_note) : 32'(REST_NOTE));
    check("note_valid", note_valid, 32'(m_state == M_BUSY));
    check("busy",       busy,       32'(m_state == M_BUSY));
    check("beat_tick",  beat_tick,  32'(m_tick));
    check("done",       done,       32'(m_done));
  endtask

  task automatic idle_cycles(input int n, input bit l);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, l);
  endtask

  initial begin
    // Reset state.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    check("rst_note", note, 63);
    check("rst_busy", busy, 0);

    // Full song: ticks at 4, 8, 12, done at 12; start in DONE is ignored.
    cycle(0, 1, 0, 0, 0);
    check("play_note0", note, 0);
    check("play_valid", note_valid, 1);
    idle_cycles(4, 0);
    check("c4_tick", beat_tick, 1);
    check("c4_note", note, 1);
    idle_cycles(4, 0);
    check("c8_note", note, 2);
    idle_cycles(4, 0);
    check("c12_done", done, 1);
    check("c12_tick", beat_tick, 1);
    check("c12_note", note, 63);
    cycle(0, 1, 0, 0, 0);
    check("done_start_ign", busy, 0);
    check("done_pulse_end", done, 0);

    // Pause for 3 cycles in step 1 (start pulsed while paused): step 1 lasts 7 cycles.
    cycle(0, 1, 0, 0, 0);
    idle_cycles(4, 0);
    check("p_c4_note", note, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    idle_cycles(3, 0);
    check("p_c10_note", note, 1);
    check("p_c10_tick", beat_tick, 0);
    cycle(0, 0, 0, 0, 0);
    check("p_c11_note", note, 2);
    check("p_c11_tick", beat_tick, 1);

    // Stop together with start while playing.
    cycle(0, 1, 1, 0, 0);
    check("stop_note", note, 63);
    check("stop_done", done, 0);
    idle_cycles(2, 0);
    check("stop_idle", busy, 0);

    // Pause rising on the final count of a step: boundary completes, then hold.
    cycle(0, 1, 0, 0, 0);
    idle_cycles(3, 0);
    cycle(0, 0, 0, 1, 0);
    check("pb_tick", beat_tick, 1);
    check("pb_note", note, 1);
    cycle(0, 0, 0, 1, 0);
    check("pb_hold_tick", beat_tick, 0);
    check("pb_hold_valid", note_valid, 1);
    cycle(0, 0, 1, 1, 0);

    // Reset during step 1, then restart from step 0.
    cycle(0, 1, 0, 0, 0);
    idle_cycles(5, 0);
    check("r_step1", note, 1);
    cycle(1, 0, 0, 0, 0);
    check("r_note", note, 63);
    check("r_valid", note_valid, 0);
    cycle(0, 1, 0, 0, 0);
    check("r_restart", note, 0);
    cycle(0, 0, 1, 0, 0);

`ifdef SEQ_LOOP_EN
    // Loop: 0,1,2,0,1 with no done; dropping loop ends after the next step 2.
    cycle(0, 1, 0, 0, 1);
    idle_cycles(12, 1);
    check("lp_wrap_note", note, 0);
    check("lp_wrap_done", done, 0);
    idle_cycles(4, 1);
    check("lp_note1", note, 1);
    idle_cycles(8, 0);
    check("lp_end_done", done, 1);
`endif

    // Randomized control against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
